// File: rtl/program_loader.sv
// Receives a framed program image over the UART byte stream and writes it into
// program RAM as 16-bit words, holding the core in reset until the image verifies.
module program_loader #(
    parameter int unsigned ADDRESS_WIDTH  = 10,
    parameter logic [7:0]  START_BYTE     = 8'h4C,
    parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [15:0]              mem_data_out,
    output logic                     mem_write_enable,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int unsigned IW    = ADDRESS_WIDTH + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        IDLE, COUNT_HI, COUNT_LO, DATA_HI, DATA_LO, CHECKSUM, DONE, ERROR
    } state_t;

    state_t          state_q;
    logic [15:0]     count_q;
    logic [IW-1:0]   word_idx_q;
    logic [7:0]      hi_q;
    logic [7:0]      checksum_q;
    logic [TW-1:0]   timeout_q;

    logic [15:0]     count_full_d;
    logic [7:0]      checksum_d;
    logic [IW-1:0]   word_idx_d;
    logic            last_word_d;
    logic            in_session_d;
    logic            timeout_hit_d;

    // Word index is one bit wider than the address so N == 2^ADDRESS_WIDTH is countable.
    always_comb begin
        count_full_d  = {count_q[15:8], rx_data};
        checksum_d    = checksum_q + rx_data;
        word_idx_d    = word_idx_q + IW'(1);
        last_word_d   = (32'(word_idx_d) == 32'(count_q));
        in_session_d  = (state_q == COUNT_HI) || (state_q == COUNT_LO) ||
                        (state_q == DATA_HI)  || (state_q == DATA_LO)  ||
                        (state_q == CHECKSUM);
        timeout_hit_d = in_session_d && !rx_valid &&
                        (timeout_q == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            count_q          <= '0;
            word_idx_q       <= '0;
            hi_q             <= '0;
            checksum_q       <= '0;
            timeout_q        <= '0;
            mem_address      <= '0;
            mem_data_out     <= '0;
            mem_write_enable <= 1'b0;
            cpu_hold         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            mem_write_enable <= 1'b0;

            if (in_session_d) begin
                timeout_q <= rx_valid ? '0 : timeout_q + TW'(1);
            end else begin
                timeout_q <= '0;
            end

            // A stalled sender aborts the session; cpu_hold stays asserted.
            if (timeout_hit_d) begin
                state_q   <= ERROR;
                error     <= 1'b1;
                busy      <= 1'b0;
                timeout_q <= '0;
            end else if (rx_valid) begin
                case (state_q)
                    IDLE, DONE, ERROR: begin
                        if (rx_data == START_BYTE) begin
                            state_q     <= COUNT_HI;
                            done        <= 1'b0;
                            error       <= 1'b0;
                            checksum_q  <= '0;
                            mem_address <= '0;
                            word_idx_q  <= '0;
                            busy        <= 1'b1;
                            cpu_hold    <= 1'b1;
                        end
                    end
                    COUNT_HI: begin
                        count_q <= {rx_data, 8'h00};
                        state_q <= COUNT_LO;
                    end
                    COUNT_LO: begin
                        count_q <= count_full_d;
                        if (32'(count_full_d) > DEPTH) begin
                            state_q <= ERROR;
                            error   <= 1'b1;
                            busy    <= 1'b0;
                        end else if (count_full_d == 16'h0000) begin
                            state_q <= CHECKSUM;
                        end else begin
                            state_q <= DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        hi_q       <= rx_data;
                        checksum_q <= checksum_d;
                        state_q    <= DATA_LO;
                    end
                    DATA_LO: begin
                        checksum_q       <= checksum_d;
                        mem_data_out     <= {hi_q, rx_data};
                        mem_address      <= word_idx_q[ADDRESS_WIDTH-1:0];
                        mem_write_enable <= 1'b1;
                        word_idx_q       <= word_idx_d;
                        state_q          <= last_word_d ? CHECKSUM : DATA_HI;
                    end
                    CHECKSUM: begin
                        busy <= 1'b0;
                        if (rx_data == checksum_q) begin
                            state_q  <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            error   <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
